// File: rtl/processador_pkg.sv
// Shared definitions for the processor front end: opcodes, fetch FSM states
// and the default execution watchdog limit.
package processador_pkg;

    localparam logic [3:0] OP_MV   = 4'b0000;
    localparam logic [3:0] OP_MVI  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_LD   = 4'b0100;
    localparam logic [3:0] OP_ST   = 4'b0101;
    localparam logic [3:0] OP_MVNZ = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_B    = 4'b1000;
    localparam logic [3:0] OP_PUSH = 4'b1001;
    localparam logic [3:0] OP_POP  = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_FETCH_IMM,
        S_WAIT_IMM,
        S_LOAD_IMM,
        S_EXEC,
        S_HALTED
    } state_t;

endpackage

// File: rtl/watchdog_exec.sv
// Saturating cycle counter guarding the EXEC phase; expired is high while
// the count sits at TIMEOUT.
module watchdog_exec
    import processador_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == LIMIT);

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch/sequencer: reads opcode (and MVI immediate) words from a
// synchronous program memory and drives the run/done handshake to controle.
module busca_instrucao
    import processador_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [15:0]       mem_q,
    output logic [9:0]        ir,
    output logic [15:0]       din,
    output logic              run,
    input  logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [15:0]       instr_count
);

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        w_opcode;
    logic              w_expired;
    logic              w_run_next;
    logic              w_rden_next;
    logic              w_busy_next;
    logic [ADDR_W-1:0] r_pc;
    logic [9:0]        r_ir;
    logic [15:0]       r_din;
    logic              r_run;
    logic              r_mem_rden;
    logic              r_busy;
    logic              r_halted;
    logic              r_err;
    logic [15:0]       r_instr_count;

    assign w_opcode = mem_q[9:6];

    // The counter tracks cycles spent in EXEC including the current one,
    // so expiry lands exactly on the TIMEOUT-th EXEC cycle.
    watchdog_exec #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (w_state_next != S_EXEC),
        .enable  (w_state_next == S_EXEC),
        .expired (w_expired)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_HALTED: if (start) w_state_next = S_FETCH;
            S_FETCH:          w_state_next = S_WAIT;
            S_WAIT:           w_state_next = S_LOAD;
            S_LOAD: begin
                if (w_opcode == OP_HALT)     w_state_next = S_HALTED;
                else if (w_opcode == OP_MVI) w_state_next = S_FETCH_IMM;
                else                         w_state_next = S_EXEC;
            end
            S_FETCH_IMM:      w_state_next = S_WAIT_IMM;
            S_WAIT_IMM:       w_state_next = S_LOAD_IMM;
            S_LOAD_IMM:       w_state_next = S_EXEC;
            // done takes priority over an expiring watchdog
            S_EXEC: begin
                if (done)           w_state_next = S_FETCH;
                else if (w_expired) w_state_next = S_HALTED;
            end
            default:          w_state_next = S_IDLE;
        endcase
    end

    // Handshake/status outputs are registered from the next state so they
    // line up with the state they describe, with no path from done to run.
    always_comb begin
        w_run_next  = (w_state_next == S_EXEC);
        w_rden_next = (w_state_next == S_FETCH) || (w_state_next == S_FETCH_IMM);
        w_busy_next = (w_state_next != S_IDLE) && (w_state_next != S_HALTED);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc          <= START_ADDR;
            r_ir          <= '0;
            r_din         <= '0;
            r_run         <= 1'b0;
            r_mem_rden    <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_err         <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_run      <= w_run_next;
            r_mem_rden <= w_rden_next;
            r_busy     <= w_busy_next;
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        r_pc          <= START_ADDR;
                        r_halted      <= 1'b0;
                        r_err         <= 1'b0;
                        r_instr_count <= '0;
                    end
                end
                S_LOAD: begin
                    r_pc <= r_pc + 1'b1;
                    if (w_opcode == OP_HALT) r_halted <= 1'b1;
                    else                     r_ir     <= mem_q[9:0];
                end
                S_LOAD_IMM: begin
                    r_din <= mem_q;
                    r_pc  <= r_pc + 1'b1;
                end
                S_EXEC: begin
                    if (done) begin
                        r_instr_count <= r_instr_count + 1'b1;
                    end else if (w_expired) begin
                        r_err    <= 1'b1;
                        r_halted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr    = r_pc;
    assign mem_rden    = r_mem_rden;
    assign ir          = r_ir;
    assign din         = r_din;
    assign run         = r_run;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign err         = r_err;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: table of small programs with expected
// results, plus hand sequences for ignored start/done and reset during EXEC.
module tb_busca_instrucao;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [7:0]  mem_addr;
    logic        mem_rden;
    logic [15:0] mem_q = '0;
    logic [9:0]  ir;
    logic [15:0] din;
    logic        run;
    logic        done;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        err;
    logic [15:0] instr_count;

    logic [15:0] rom [256];

    int n_vec = 0;
    int n_bad = 0;

    busca_instrucao #(
        .ADDR_W     (8),
        .START_ADDR (8'hFF),
        .TIMEOUT    (15)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_rden    (mem_rden),
        .mem_q       (mem_q),
        .ir          (ir),
        .din         (din),
        .run         (run),
        .done        (done),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_rden) mem_q <= rom[mem_addr];
    end

    typedef struct {
        logic [15:0] w0;        // at START_ADDR (0xFF)
        logic [15:0] w1;        // at 0x00 after wrap
        logic [15:0] w2;        // at 0x01
        int          done_lat;  // run cycle on which done is driven, 0 = never
        int          exp_rise;  // cycle after start at which run first rises, 0 = never
        logic [9:0]  exp_ir;
        logic [15:0] exp_din;
        int          exp_len;   // run-high cycles of the first instruction
        logic [15:0] exp_count;
        logic [7:0]  exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill_rom(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        for (int a = 0; a < 256; a++) rom[a] = 16'h03C0;
        rom[8'hFF] = w0;
        rom[8'h00] = w1;
        rom[8'h01] = w2;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         cyc;
        int         rc;
        int         rise;
        int         len;
        bit         first_done;
        bit         stable;
        bit         finished;
        logic [9:0] ir_cap;
        logic [15:0] din_cap;
        logic [9:0] cur_ir;
        logic [15:0] cur_din;
        cyc = 0; rc = 0; rise = 0; len = 0;
        first_done = 0; stable = 1; finished = 0;
        ir_cap = '0; din_cap = '0; cur_ir = '0; cur_din = '0;
        fill_rom(v.w0, v.w1, v.w2);
        @(negedge clock);
        start = 1'b1;
        while (!finished && cyc < 300) begin
            @(negedge clock);
            cyc++;
            start = 1'b0;
            if (run) begin
                rc++;
                if (rc == 1) begin
                    cur_ir  = ir;
                    cur_din = din;
                end else if (ir !== cur_ir || din !== cur_din) begin
                    stable = 0;
                end
                if (rise == 0) begin
                    rise    = cyc;
                    ir_cap  = ir;
                    din_cap = din;
                end
                if (!first_done) len++;
                done = (v.done_lat != 0) && (rc == v.done_lat);
                if (done) first_done = 1;
            end else begin
                rc   = 0;
                done = 1'b0;
            end
            if (halted && !busy) finished = 1;
        end
        done = 1'b0;
        check($sformatf("v%0d_finished", idx), 32'(finished), 32'd1);
        check($sformatf("v%0d_run_rise", idx), rise, v.exp_rise);
        if (v.exp_rise != 0) begin
            check($sformatf("v%0d_ir", idx), 32'(ir_cap), 32'(v.exp_ir));
            check($sformatf("v%0d_din", idx), 32'(din_cap), 32'(v.exp_din));
            check($sformatf("v%0d_stable", idx), 32'(stable), 32'd1);
            check($sformatf("v%0d_run_len", idx), len, v.exp_len);
        end
        check($sformatf("v%0d_count", idx), 32'(instr_count), 32'(v.exp_count));
        check($sformatf("v%0d_pc", idx), 32'(pc), 32'(v.exp_pc));
        check($sformatf("v%0d_halted", idx), 32'(halted), 32'd1);
        check($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
        check($sformatf("v%0d_run_low", idx), 32'(run), 32'd0);
        $display("vec %0d: rise=%0d ir=%03h din=%04h len=%0d count=%0d pc=%02h err=%0b",
                 idx, rise, ir_cap, din_cap, len, instr_count, pc, err);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        vecs[0] = '{16'h0000, 16'h03C0, 16'h03C0, 2, 4, 10'h000, 16'h0000, 2,  16'd1, 8'h01, 1'b0};
        vecs[1] = '{16'h0048, 16'h1234, 16'h03C0, 3, 7, 10'h048, 16'h1234, 3,  16'd1, 8'h02, 1'b0};
        vecs[2] = '{16'h0089, 16'h03C0, 16'h03C0, 0, 4, 10'h089, 16'h1234, 15, 16'd0, 8'h00, 1'b1};
        vecs[3] = '{16'h0100, 16'h0140, 16'h03C0, 1, 4, 10'h100, 16'h1234, 1,  16'd2, 8'h02, 1'b0};
        vecs[4] = '{16'h03C0, 16'h0000, 16'h0000, 1, 0, 10'h000, 16'h0000, 0,  16'd0, 8'h00, 1'b0};

        resetn = 1'b0;
        start  = 1'b0;
        done   = 1'b0;
        fill_rom(16'h03C0, 16'h03C0, 16'h03C0);
        repeat (2) @(negedge clock);
        check("rst_pc", 32'(pc), 32'hFF);
        check("rst_run", 32'(run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_rden", 32'(mem_rden), 32'd0);
        resetn = 1'b1;
        // post-reset done pulse from the controller must be ignored
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        @(negedge clock);
        check("postrst_done_busy", 32'(busy), 32'd0);
        check("postrst_done_count", 32'(instr_count), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // done during WAIT and start while busy must not disturb anything
        fill_rom(16'h0000, 16'h0000, 16'h03C0);
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        check("seqA_fetch_rden", 32'(mem_rden), 32'd1);
        @(negedge clock); start = 1'b1; done = 1'b1;
        @(negedge clock); start = 1'b0; done = 1'b0;
        check("seqA_load_count", 32'(instr_count), 32'd0);
        check("seqA_load_busy", 32'(busy), 32'd1);
        check("seqA_load_run", 32'(run), 32'd0);
        @(negedge clock);
        check("seqA_exec_run", 32'(run), 32'd1);
        check("seqA_exec_pc", 32'(pc), 32'h00);
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        check("seqA_start_busy_run", 32'(run), 32'd1);
        check("seqA_start_busy_pc", 32'(pc), 32'h00);
        done = 1'b1;
        @(negedge clock); done = 1'b0;
        check("seqA_retire_run", 32'(run), 32'd0);
        check("seqA_retire_count", 32'(instr_count), 32'd1);
        guard = 0;
        while (!(halted && !busy) && guard < 50) begin
            @(negedge clock);
            guard++;
            done = run;
        end
        done = 1'b0;
        check("seqA_halt_reached", 32'(guard < 50), 32'd1);
        check("seqA_final_count", 32'(instr_count), 32'd2);
        check("seqA_final_pc", 32'(pc), 32'h02);
        $display("seqA: count=%0d pc=%02h halted=%0b", instr_count, pc, halted);

        // asynchronous reset while run is high
        fill_rom(16'h0085, 16'h03C0, 16'h03C0);
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        guard = 0;
        while (!run && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("seqB_run_reached", 32'(run), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("seqB_async_run", 32'(run), 32'd0);
        check("seqB_async_busy", 32'(busy), 32'd0);
        check("seqB_async_pc", 32'(pc), 32'hFF);
        check("seqB_async_ir", 32'(ir), 32'd0);
        check("seqB_async_din", 32'(din), 32'd0);
        check("seqB_async_count", 32'(instr_count), 32'd0);
        check("seqB_async_halted", 32'(halted), 32'd0);
        check("seqB_async_err", 32'(err), 32'd0);
        @(negedge clock); resetn = 1'b1; done = 1'b1;
        @(negedge clock); done = 1'b0;
        @(negedge clock);
        check("seqB_idle_busy", 32'(busy), 32'd0);
        check("seqB_idle_run", 32'(run), 32'd0);
        check("seqB_idle_count", 32'(instr_count), 32'd0);
        check("seqB_idle_pc", 32'(pc), 32'hFF);
        check("seqB_idle_rden", 32'(mem_rden), 32'd0);
        $display("seqB: run=%0b busy=%0b pc=%02h", run, busy, pc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
